// File: rtl/iq_stream_arbiter.sv
// Round-robin arbiter merging PORTS joined-IQ streams into one registered
// output stream tagged with source ID and an end-of-burst marker.
module iq_stream_arbiter #(
    parameter int unsigned PORTS    = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ID_WIDTH = 2,
    parameter int unsigned BURST    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS*WIDTH-1:0]   input_i_tdata,
    input  logic [PORTS*WIDTH-1:0]   input_q_tdata,
    input  logic [PORTS-1:0]         input_tvalid,
    output logic [PORTS-1:0]         input_tready,
    output logic [WIDTH-1:0]         output_i_tdata,
    output logic [WIDTH-1:0]         output_q_tdata,
    output logic [ID_WIDTH-1:0]      output_tid,
    output logic                     output_tlast,
    output logic                     output_tvalid,
    input  logic                     output_tready
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);
    localparam logic [ID_WIDTH-1:0] RST_LAST_GRANT = ID_WIDTH'(PORTS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                state_q;
    logic [ID_WIDTH-1:0]   grant_q;
    logic [ID_WIDTH-1:0]   last_grant_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [WIDTH-1:0]      out_i_q;
    logic [WIDTH-1:0]      out_q_q;
    logic [ID_WIDTH-1:0]   out_tid_q;
    logic                  out_last_q;
    logic                  out_valid_q;

    logic [PORTS-1:0]      grant_oh;
    logic                  grant_valid;
    logic [WIDTH-1:0]      sel_i;
    logic [WIDTH-1:0]      sel_q;
    logic                  ready_g;
    logic                  xfer;
    logic                  pick_valid;
    logic [ID_WIDTH-1:0]   pick_id;

    // Round-robin search starting just after the previous winner
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned off = 1; off <= PORTS; off++) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (!pick_valid && input_tvalid[p] &&
                    (p == (32'(last_grant_q) + off) % PORTS)) begin
                    pick_valid = 1'b1;
                    pick_id    = ID_WIDTH'(p);
                end
            end
        end
    end

    // Decode the granted port and mux its sample
    always_comb begin
        grant_oh = '0;
        sel_i    = '0;
        sel_q    = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (32'(grant_q) == p) begin
                grant_oh[p] = 1'b1;
                sel_i       = input_i_tdata[p*WIDTH +: WIDTH];
                sel_q       = input_q_tdata[p*WIDTH +: WIDTH];
            end
        end
    end

    assign grant_valid  = |(input_tvalid & grant_oh);
    assign ready_g      = (state_q == S_GRANT) && rst && (!out_valid_q || output_tready);
    assign xfer         = ready_g && grant_valid;
    assign input_tready = ready_g ? grant_oh : '0;
    assign count_d      = count_q + CNT_W'(1);

    // Arbitration FSM and output register; a load overrides the drain
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= RST_LAST_GRANT;
            count_q      <= '0;
            out_i_q      <= '0;
            out_q_q      <= '0;
            out_tid_q    <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            if (out_valid_q && output_tready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_id;
                        last_grant_q <= pick_id;
                        count_q      <= '0;
                        state_q      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (xfer) begin
                        out_i_q     <= sel_i;
                        out_q_q     <= sel_q;
                        out_tid_q   <= grant_q;
                        out_last_q  <= (count_q == LAST_CNT);
                        out_valid_q <= 1'b1;
                        count_q     <= count_d;
                        if (count_q == LAST_CNT) begin
                            state_q <= S_IDLE;
                        end
                    end else if (ready_g && !grant_valid) begin
                        // Source went quiet: release without tlast
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign output_i_tdata = out_i_q;
    assign output_q_tdata = out_q_q;
    assign output_tid     = out_tid_q;
    assign output_tlast   = out_last_q;
    assign output_tvalid  = out_valid_q;

endmodule

// File: tb/tb_iq_stream_arbiter.sv
// Self-checking bench for iq_stream_arbiter: randomized sample data, expected
// stream built from the round-robin/burst rules with plain arithmetic.
module tb_iq_stream_arbiter;

    localparam int unsigned P   = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned IDW = 2;
    localparam int unsigned B   = 4;
    localparam int unsigned NS  = 64;

    typedef struct packed {
        logic [IDW-1:0] tid;
        logic           last;
        logic [W-1:0]   i;
        logic [W-1:0]   q;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [P*W-1:0]   i_data;
    logic [P*W-1:0]   q_data;
    logic [P-1:0]     in_valid;
    logic [P-1:0]     in_ready;
    logic [W-1:0]     out_i;
    logic [W-1:0]     out_q;
    logic [IDW-1:0]   out_tid;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    logic [W-1:0]     src_i [P][NS];
    logic [W-1:0]     src_q [P][NS];
    int               idx [P];
    int               lim [P];
    logic [P-1:0]     en;
    bit               rand_rdy;
    exp_t             exp_q[$];
    int               pop_cyc[$];
    int               cyc;
    int               tests;
    int               fails;

    iq_stream_arbiter #(.PORTS(P), .WIDTH(W), .ID_WIDTH(IDW), .BURST(B)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_i_tdata (i_data),
        .input_q_tdata (q_data),
        .input_tvalid  (in_valid),
        .input_tready  (in_ready),
        .output_i_tdata(out_i),
        .output_q_tdata(out_q),
        .output_tid    (out_tid),
        .output_tlast  (out_last),
        .output_tvalid (out_valid),
        .output_tready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic new_data(input bit ramp);
        for (int p = 0; p < int'(P); p++) begin
            idx[p] = 0;
            lim[p] = 0;
            for (int n = 0; n < int'(NS); n++) begin
                src_i[p][n] = ramp ? W'(n)  : W'($urandom);
                src_q[p][n] = ramp ? W'(-n) : W'($urandom);
            end
        end
    endtask

    task automatic push_exp(input int p, input int n, input bit last);
        exp_t e;
        e.tid  = IDW'(p);
        e.last = last;
        e.i    = src_i[p][n];
        e.q    = src_q[p][n];
        exp_q.push_back(e);
    endtask

    // Continuous traffic on all ports: bursts rotate 0,1,2,3,0,... each B long
    task automatic push_rr(input int nb);
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < int'(B); j++) begin
                push_exp(b % int'(P), (b / int'(P)) * int'(B) + j, j == int'(B) - 1);
            end
        end
    endtask

    // One clock: drive at negedge, check, then sample handshakes at posedge
    task automatic cycle();
        bit          fire_out;
        bit [P-1:0]  fire_in;
        exp_t        h;
        for (int p = 0; p < int'(P); p++) begin
            in_valid[p]       = en[p] && (idx[p] < lim[p]);
            i_data[p*W +: W]  = (idx[p] < int'(NS)) ? src_i[p][idx[p]] : '0;
            q_data[p*W +: W]  = (idx[p] < int'(NS)) ? src_q[p][idx[p]] : '0;
        end
        out_ready = rand_rdy ? ($urandom_range(0, 99) < 60) : 1'b1;
        #1;
        check("tready_onehot0", 64'($onehot0(in_ready)), 64'(1));
        if (out_valid === 1'b1 && out_ready === 1'b0)
            check("stall_tready_zero", 64'(in_ready), 64'(0));
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(out_valid), 64'(0));
            end else begin
                h = exp_q[0];
                check("out_sample", 64'({out_tid, out_last, out_i, out_q}), 64'(h));
            end
        end
        fire_out = (out_valid === 1'b1) && out_ready;
        for (int p = 0; p < int'(P); p++)
            fire_in[p] = in_valid[p] && (in_ready[p] === 1'b1);
        @(posedge clk);
        cyc++;
        for (int p = 0; p < int'(P); p++)
            if (fire_in[p]) idx[p]++;
        if (fire_out && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            pop_cyc.push_back(cyc);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        exp_q.delete();
        pop_cyc.delete();
    endtask

    task automatic run_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
        repeat (3) cycle();
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rand_rdy = 1'b0;
        rst = 1'b0;
        en = '0;
        in_valid = '0; i_data = '0; q_data = '0; out_ready = 1'b1;
        new_data(1'b0);
        @(negedge clk);

        // Reset with all sources requesting
        en = '1;
        for (int p = 0; p < int'(P); p++) lim[p] = int'(NS);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("rst_outputs", 64'({out_i, out_q, out_tid, out_last, out_valid, in_ready}), 64'(0));
        end
        rst = 1'b1;
        cycle();
        check("post_rst_valid", 64'(out_valid), 64'(0));
        check("post_rst_tready", 64'(in_ready), 64'(4'b0001));
        en = '0;
        repeat (2) cycle();

        // Single source on port 2 with I=n, Q=-n
        do_reset();
        new_data(1'b1);
        en = 4'b0100; lim[2] = 12;
        for (int n = 0; n < 12; n++) push_exp(2, n, (n % int'(B)) == int'(B) - 1);
        run_drain(200);
        check("single_span", 64'(pop_cyc[11] - pop_cyc[0]), 64'(13));

        // All four ports continuously valid
        do_reset();
        new_data(1'b0);
        en = '1;
        for (int p = 0; p < int'(P); p++) lim[p] = 8;
        push_rr(8);
        run_drain(300);
        check("rr_span", 64'(pop_cyc[31] - pop_cyc[0]), 64'(38));

        // Early release of port 1 after two samples, port 3 waiting
        do_reset();
        new_data(1'b0);
        en = 4'b1010; lim[1] = 2; lim[3] = 4;
        push_exp(1, 0, 1'b0);
        push_exp(1, 1, 1'b0);
        for (int n = 0; n < 4; n++) push_exp(3, n, n == 3);
        run_drain(100);
        check("early_gap", 64'(pop_cyc[2] - pop_cyc[1]), 64'(3));

        // Random output backpressure under full 4-port load
        do_reset();
        new_data(1'b0);
        en = '1;
        for (int p = 0; p < int'(P); p++) lim[p] = 24;
        push_rr(24);
        rand_rdy = 1'b1;
        run_drain(2000);
        for (int p = 0; p < int'(P); p++)
            check("bp_consumed", 64'(idx[p]), 64'(24));
        rand_rdy = 1'b0;

        // Reset on the third sample of a burst
        do_reset();
        new_data(1'b0);
        en = '1;
        for (int p = 0; p < int'(P); p++) lim[p] = int'(NS);
        for (int n = 0; n < 3; n++) push_exp(0, n, 1'b0);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 1 && n < 50) begin
                cycle();
                n++;
            end
        end
        check("mid_reach_third", 64'({exp_q.size() == 1, out_valid}), 64'(2'b11));
        rst = 1'b0;
        cycle();
        exp_q.delete();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_tready", 64'(in_ready), 64'(0));
        rst = 1'b1;
        cycle();
        check("mid_regrant_port0", 64'(in_ready), 64'(4'b0001));
        en = '0;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iq_stream_arbiter.md
# iq_stream_arbiter

Round-robin arbiter that shares one downstream joined-IQ sample path among PORTS joined-IQ sources. Each source presents I/Q sample pairs on a common valid/ready handshake. Grants last for bursts of up to BURST samples. The merged stream carries a source ID and an end-of-burst marker, so a single downstream DSP chain (mixer, filter, DMA) can be time-shared between channels.

## Interface

Parameters:
- PORTS, 4: number of IQ sources (2..16).
- WIDTH, 16: bits per I and per Q sample.
- ID_WIDTH, 2: width of output_tid; must satisfy 2^ID_WIDTH >= PORTS.
- BURST, 16: maximum samples per grant (1..65535).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-low (0 = reset).
- input_i_tdata  in  PORTS*WIDTH  I samples; port n occupies bits [n*WIDTH +: WIDTH].
- input_q_tdata  in  PORTS*WIDTH  Q samples, same packing.
- input_tvalid  in  PORTS  per-port valid.
- input_tready  out  PORTS  per-port ready; at most one bit high.
- output_i_tdata  out  WIDTH  registered I sample.
- output_q_tdata  out  WIDTH  registered Q sample.
- output_tid  out  ID_WIDTH  source port of the current output sample.
- output_tlast  out  1  high on the BURST-th sample of a grant.
- output_tvalid  out  1  output valid.
- output_tready  in  1  downstream ready.

## Operation

- State machine has two states: IDLE and GRANT. Registers: grant (ID_WIDTH), last_grant (ID_WIDTH), count (16 bits), plus the output register.
- IDLE:
  - If any input_tvalid is high, select the first asserted port, searching from last_grant+1 upward with wrap at PORTS-1 to 0.
  - Load grant and last_grant with that port, clear count, go to GRANT.
  - All input_tready bits stay low in IDLE.
- GRANT:
  - input_tready[grant] = ~output_tvalid | output_tready. All other ready bits are 0.
  - A transfer occurs when input_tvalid[grant] and input_tready[grant] are both high. On a transfer:
    - The output register loads I/Q from port grant.
    - output_tid <= grant.
    - output_tlast <= (count == BURST-1).
    - output_tvalid <= 1.
    - count increments.
  - Transfer with count == BURST-1: return to IDLE (burst complete).
  - No transfer because input_tvalid[grant] is low: return to IDLE (early release; no tlast emitted).
  - Cycles where input_tready[grant] is low (output stalled) hold state and count. They do not release the grant.
- Output register: when output_tvalid is high and output_tready is high with no new load, output_tvalid <= 0. Load and drain in the same cycle keep output_tvalid high.
- Output data, tid and tlast are stable while output_tvalid is high and output_tready is low.
- Fairness: after port k is granted, port k has lowest priority in the next arbitration.

## Timing

- Reset values (rst low at a clock edge):
  - state = IDLE.
  - last_grant = PORTS-1, so port 0 wins first.
  - grant = 0, count = 0.
  - output_tvalid = 0, output_tlast = 0, output_tid = 0, output_i_tdata = 0, output_q_tdata = 0.
  - input_tready = 0.
- Reset asserted mid-burst aborts the burst immediately. Any pending output sample is dropped (output_tvalid = 0 on the next cycle).
- Arbitration latency: 1 cycle from input_tvalid rising in IDLE to input_tready high.
- Data latency: 1 cycle from input handshake to output_tvalid.
- Sustained throughput: BURST samples per BURST+1 cycles per grant (one IDLE cycle between grants), with output_tready held high.
- Simultaneous requests: the round-robin order decides; requests from ungranted ports wait with tready low, and their data must be held by the source.
- BURST = 1: every sample carries tlast, and an IDLE cycle follows each sample.
- Full backpressure: with output_tready low and output_tvalid high, all input_tready bits are 0 and no state changes.

## Test plan

- Reset: hold rst = 0 for 3 cycles with all tvalid high. Required: all outputs 0. After release, output_tvalid stays 0 for 1 cycle, then input_tready = 4'b0001.
- Single source: port 2 continuously valid with I = n, Q = -n, BURST = 4, output_tready = 1. Required:
  - outputs I = 0..3 with tid = 2 and tlast on I = 3;
  - one cycle with input_tready = 0;
  - the next burst starts at I = 4.
- Round robin: all four ports continuously valid, BURST = 4. Required:
  - tid sequence 0,0,0,0,1,1,1,1,2,…,3,…,0;
  - no port granted twice before every other valid port has been granted.
- Early release: port 1 valid for 2 samples, then tvalid low, while port 3 is valid. Required: two port-1 outputs with tlast = 0, then the grant moves to port 3 after one IDLE cycle.
- Backpressure: toggle output_tready pseudo-randomly during 4-port traffic. Required:
  - every input sample appears exactly once, in order per port;
  - data is stable while stalled;
  - tlast appears every BURST samples per grant.
- Mid-burst reset: assert rst = 0 on the 3rd sample of a burst. Required: output_tvalid = 0 and input_tready = 0 the next cycle, and the first grant after reset goes to port 0.
